// File: rtl/div_issue_ctrl_pkg.sv
// Shared encodings and widths for the EX-stage divide initiator.
// Names match the legacy defines include so the MIPS core can keep using them.
package div_issue_ctrl_pkg;

    localparam int RegBus       = 32;
    localparam int DoubleRegBus = 64;

    localparam logic [1:0] DIVC_IDLE  = 2'd0;
    localparam logic [1:0] DIVC_BUSY  = 2'd1;
    localparam logic [1:0] DIVC_DONE  = 2'd2;
    localparam logic [1:0] DIVC_ABORT = 2'd3;

    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

endpackage

// File: rtl/div_issue_ctrl.sv
// EX-stage initiator for the iterative divider: launches, holds operands,
// stalls the pipeline and returns {HI, LO}; survives flushes mid-divide.
module div_issue_ctrl
    import div_issue_ctrl_pkg::*;
#(
    parameter int DATA_W      = RegBus,
    parameter int TIMEOUT_CYC = 40
) (
    input  logic                cpu_clk_75M,
    input  logic                cpu_rst,
    input  logic                div_valid_i,
    input  logic                signed_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    input  logic                flush_i,
    input  logic [2*DATA_W-1:0] div_result_i,
    input  logic                div_ready_i,
    output logic                div_start_o,
    output logic                signed_div_o,
    output logic [DATA_W-1:0]   div_opdata1_o,
    output logic [DATA_W-1:0]   div_opdata2_o,
    output logic                stallreq_o,
    output logic [DATA_W-1:0]   hi_o,
    output logic [DATA_W-1:0]   lo_o,
    output logic                whilo_o,
    output logic                div_err_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [1:0]        r_state;
    logic              r_start;
    logic              r_signed;
    logic [DATA_W-1:0] r_op1;
    logic [DATA_W-1:0] r_op2;
    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_err;
    logic              w_stall;
    logic              w_whilo;
    logic              w_ready;

    assign w_ready = (div_ready_i == DivResultReady);

    always_ff @(posedge cpu_clk_75M) begin
        if (cpu_rst) begin
            r_state  <= DIVC_IDLE;
            r_start  <= DivStop;
            r_signed <= 1'b0;
            r_op1    <= '0;
            r_op2    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_cnt    <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                DIVC_IDLE: begin
                    if (div_valid_i && !flush_i) begin
                        r_op1    <= opdata1_i;
                        r_op2    <= opdata2_i;
                        r_signed <= signed_i;
                        r_start  <= DivStart;
                        r_state  <= DIVC_BUSY;
                    end
                end
                DIVC_BUSY: begin
                    // A flush beats a coincident ready: the result belongs to a killed instruction.
                    if (flush_i) begin
                        if (w_ready) begin
                            r_start <= DivStop;
                            r_state <= DIVC_IDLE;
                        end else begin
                            r_state <= DIVC_ABORT;
                        end
                    end else if (w_ready) begin
                        r_hi    <= div_result_i[2*DATA_W-1:DATA_W];
                        r_lo    <= div_result_i[DATA_W-1:0];
                        r_start <= DivStop;
                        r_state <= DIVC_DONE;
                    end
                end
                DIVC_DONE: r_state <= DIVC_IDLE;
                DIVC_ABORT: begin
                    // Divider has no cancel; keep start asserted until it reaches its end state.
                    if (w_ready) begin
                        r_start <= DivStop;
                        r_state <= DIVC_IDLE;
                    end
                end
                default: r_state <= DIVC_IDLE;
            endcase

            if (r_state == DIVC_BUSY || r_state == DIVC_ABORT) begin
                if (r_cnt != CNT_W'(TIMEOUT_CYC))
                    r_cnt <= r_cnt + 1'b1;
                if (r_cnt == CNT_W'(TIMEOUT_CYC - 1))
                    r_err <= 1'b1;
            end else begin
                r_cnt <= '0;
            end
        end
    end

    always_comb begin
        w_stall = 1'b0;
        w_whilo = 1'b0;
        case (r_state)
            DIVC_IDLE:  w_stall = div_valid_i & ~flush_i;
            DIVC_BUSY:  w_stall = 1'b1;
            DIVC_DONE:  w_whilo = div_valid_i & ~flush_i;
            DIVC_ABORT: w_stall = div_valid_i;
            default:    w_stall = 1'b0;
        endcase
    end

    assign div_start_o   = r_start;
    assign signed_div_o  = r_signed;
    assign div_opdata1_o = r_op1;
    assign div_opdata2_o = r_op2;
    assign stallreq_o    = w_stall;
    assign hi_o          = r_hi;
    assign lo_o          = r_lo;
    assign whilo_o       = w_whilo;
    assign div_err_o     = r_err;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl with a behavioural start/ready divider beside it.
module tb_div_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic        sgn = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic [63:0] res;
    logic        rdy;

    logic        div_start_o, signed_div_o, stallreq_o, whilo_o, div_err_o;
    logic [31:0] div_opdata1_o, div_opdata2_o, hi_o, lo_o;

    int vectors = 0;
    int miscompares = 0;
    int lat = 12;
    bit stuck = 1'b0;

    always #5 clk = ~clk;

    div_issue_ctrl #(.DATA_W(32), .TIMEOUT_CYC(40)) dut (
        .cpu_clk_75M  (clk),
        .cpu_rst      (rst),
        .div_valid_i  (valid),
        .signed_i     (sgn),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .flush_i      (flush),
        .div_result_i (res),
        .div_ready_i  (rdy),
        .div_start_o  (div_start_o),
        .signed_div_o (signed_div_o),
        .div_opdata1_o(div_opdata1_o),
        .div_opdata2_o(div_opdata2_o),
        .stallreq_o   (stallreq_o),
        .hi_o         (hi_o),
        .lo_o         (lo_o),
        .whilo_o      (whilo_o),
        .div_err_o    (div_err_o)
    );

    // Truncating MIPS semantics: {remainder, quotient}; divide by zero gives 0.
    function automatic logic [63:0] ref_div(input bit s, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q, r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    // Divider: free -> busy on start, ready held in end state until start drops.
    int dst = 0;
    int dcnt = 0;
    always @(posedge clk) begin
        if (rst) begin
            dst <= 0; dcnt <= 0; rdy <= 1'b0; res <= '0;
        end else begin
            case (dst)
                0: begin
                    rdy <= 1'b0;
                    if (div_start_o) begin dst <= 1; dcnt <= lat; end
                end
                1: begin
                    if (!div_start_o) dst <= 0;
                    else if (!stuck) begin
                        if (dcnt <= 1) begin
                            rdy <= 1'b1;
                            res <= ref_div(signed_div_o, div_opdata1_o, div_opdata2_o);
                            dst <= 2;
                        end else dcnt <= dcnt - 1;
                    end
                end
                default: if (!div_start_o) begin dst <= 0; rdy <= 1'b0; res <= '0; end
            endcase
        end
    end

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic do_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input string nm);
        bit armed = 1'b0, bad = 1'b0, seen = 1'b0;
        int n;
        lat = $urandom_range(8, 24);
        sgn = s; op1 = a; op2 = b; flush = 1'b0; valid = 1'b1;
        #1;
        for (n = 0; n < 300; n++) begin
            if (!stallreq_o) break;
            if (whilo_o) bad = 1'b1;
            if (!div_start_o) armed = 1'b1;
            else if (armed) begin
                seen = 1'b1;
                if (div_opdata1_o !== a || div_opdata2_o !== b || signed_div_o !== s) bad = 1'b1;
            end
            cyc;
        end
        vectors++;
        if (n == 300) begin miscompares++; $display("FAIL %s_timeout: stall still %b after %0d cycles, expected release", nm, stallreq_o, n); end
        vectors++;
        if (bad || !seen) begin miscompares++; $display("FAIL %s_hold: launched=%b hold_violation=%b, expected launched=1 hold_violation=0", nm, seen, bad); end
        vectors++;
        if (whilo_o !== 1'b1) begin miscompares++; $display("FAIL %s_whilo: got %b expected 1", nm, whilo_o); end
        vectors++;
        if ({hi_o, lo_o} !== {ehi, elo}) begin miscompares++; $display("FAIL %s_hilo: got hi=%h lo=%h expected hi=%h lo=%h", nm, hi_o, lo_o, ehi, elo); end
        vectors++;
        if (div_start_o !== 1'b0) begin miscompares++; $display("FAIL %s_start_done: got %b expected 0", nm, div_start_o); end
        cyc;
        valid = 1'b0;
        #1;
        vectors++;
        if (whilo_o !== 1'b0 || div_start_o !== 1'b0) begin
            miscompares++; $display("FAIL %s_after: whilo=%b start=%b expected 0 0", nm, whilo_o, div_start_o);
        end
    endtask

    task automatic do_flushed(input bit s, input logic [31:0] a, input logic [31:0] b, input int fat);
        bit bad = 1'b0;
        lat = $urandom_range(8, 24);
        sgn = s; op1 = a; op2 = b; flush = 1'b0; valid = 1'b1;
        #1;
        for (int k = 0; k < fat; k++) begin
            if (whilo_o || !stallreq_o) bad = 1'b1;
            cyc;
        end
        flush = 1'b1;
        #1;
        if (whilo_o) bad = 1'b1;
        cyc;
        flush = 1'b0; valid = 1'b0;
        #1;
        vectors++;
        if (bad || whilo_o || stallreq_o) begin
            miscompares++; $display("FAIL flush_kill: bad=%b whilo=%b stall=%b expected 0 0 0", bad, whilo_o, stallreq_o);
        end
        vectors++;
        if (fat == 0) begin
            if (div_start_o !== 1'b0) begin miscompares++; $display("FAIL flush_no_launch: start=%b expected 0", div_start_o); end
        end else if (div_start_o !== 1'b1 || div_opdata1_o !== a || div_opdata2_o !== b) begin
            miscompares++; $display("FAIL abort_hold: start=%b op1=%h op2=%h expected 1 %h %h", div_start_o, div_opdata1_o, div_opdata2_o, a, b);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; valid = 1'b0; flush = 1'b0;
        cyc; cyc;
        vectors++;
        if ({div_start_o, signed_div_o, div_opdata1_o, div_opdata2_o, hi_o, lo_o, whilo_o, stallreq_o, div_err_o} !== '0) begin
            miscompares++; $display("FAIL reset_outs: start=%b sgn=%b op1=%h op2=%h hi=%h lo=%h whilo=%b stall=%b err=%b expected all 0",
                div_start_o, signed_div_o, div_opdata1_o, div_opdata2_o, hi_o, lo_o, whilo_o, stallreq_o, div_err_o);
        end
        rst = 1'b0;
        cyc;
    endtask

    task automatic test_unsigned;
        do_div(1'b0, 32'd7, 32'd2, 32'd1, 32'd3, "divu_7_2");
    endtask

    task automatic test_signed;
        do_div(1'b1, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7_2");
    endtask

    task automatic test_div_zero;
        do_div(1'b0, 32'd5, 32'd0, 32'd0, 32'd0, "div_by_zero");
    endtask

    task automatic test_flush;
        do_flushed(1'b0, 32'd100, 32'd7, 5);
        do_div(1'b0, 32'd100, 32'd7, 32'd2, 32'd14, "after_flush");
    endtask

    task automatic test_back_to_back;
        do_div(1'b0, 32'hFFFF_FFFF, 32'h10, 32'hF, 32'h0FFF_FFFF, "b2b_first");
        do_div(1'b0, 32'd9, 32'd3, 32'd0, 32'd3, "b2b_second");
    endtask

    task automatic test_random;
        logic [31:0] a, b;
        logic [63:0] e;
        bit s;
        for (int i = 0; i < 24; i++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'd0 :
                ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 15)) : $urandom;
            if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
            if ($urandom_range(0, 3) == 0) do_flushed(s, $urandom, $urandom, $urandom_range(0, 6));
            e = ref_div(s, a, b);
            do_div(s, a, b, e[63:32], e[31:0], "random");
        end
    endtask

    task automatic test_reset_mid_busy;
        lat = 20;
        sgn = 1'b1; op1 = 32'h1234; op2 = 32'h56; valid = 1'b1;
        repeat (6) cyc;
        rst = 1'b1; valid = 1'b0;
        cyc;
        vectors++;
        if ({div_start_o, signed_div_o, div_opdata1_o, div_opdata2_o, hi_o, lo_o, whilo_o, stallreq_o, div_err_o} !== '0) begin
            miscompares++; $display("FAIL reset_mid_busy: start=%b sgn=%b op1=%h op2=%h hi=%h lo=%h whilo=%b stall=%b err=%b expected all 0",
                div_start_o, signed_div_o, div_opdata1_o, div_opdata2_o, hi_o, lo_o, whilo_o, stallreq_o, div_err_o);
        end
        rst = 1'b0;
        cyc;
        do_div(1'b0, 32'd1000, 32'd33, 32'd10, 32'd30, "after_reset");
    endtask

    task automatic test_timeout;
        int n;
        stuck = 1'b1; lat = 10;
        sgn = 1'b0; op1 = 32'd50; op2 = 32'd5; valid = 1'b1;
        cyc;
        repeat (34) cyc;
        vectors++;
        if (div_err_o !== 1'b0 || stallreq_o !== 1'b1) begin
            miscompares++; $display("FAIL err_early: err=%b stall=%b expected 0 1", div_err_o, stallreq_o);
        end
        repeat (10) cyc;
        vectors++;
        if (div_err_o !== 1'b1) begin miscompares++; $display("FAIL err_set: got %b expected 1", div_err_o); end
        vectors++;
        if (stallreq_o !== 1'b1 || div_start_o !== 1'b1 || whilo_o !== 1'b0) begin
            miscompares++; $display("FAIL stuck_hold: stall=%b start=%b whilo=%b expected 1 1 0", stallreq_o, div_start_o, whilo_o);
        end
        stuck = 1'b0;
        for (n = 0; n < 100; n++) begin
            if (!stallreq_o) break;
            cyc;
        end
        vectors++;
        if (n == 100 || whilo_o !== 1'b1 || {hi_o, lo_o} !== {32'd0, 32'd10}) begin
            miscompares++; $display("FAIL stuck_release: cycles=%0d whilo=%b hi=%h lo=%h expected whilo=1 hi=0 lo=a", n, whilo_o, hi_o, lo_o);
        end
        cyc;
        valid = 1'b0;
        cyc;
        vectors++;
        if (div_err_o !== 1'b1) begin miscompares++; $display("FAIL err_sticky: got %b expected 1", div_err_o); end
        rst = 1'b1;
        cyc;
        vectors++;
        if (div_err_o !== 1'b0) begin miscompares++; $display("FAIL err_reset: got %b expected 0", div_err_o); end
        rst = 1'b0;
        cyc;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_unsigned;
        test_signed;
        test_div_zero;
        test_flush;
        test_back_to_back;
        test_random;
        test_reset_mid_busy;
        test_timeout;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
